ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//   Shares the single-port data RAM (ramlpm: registered address, 1-cycle read latency)
//   between two requesters: port P (processor load/store) and port L (loader/debug).
//   - Round-robin arbitration.
//   - Sequences each access through a fixed 3-state FSM.
//   - Returns read data or write completion with a one-cycle Ack pulse.
//   Sits between proc/loader and ramlpm in the top level.
// PARAMETERS
//   DATA_W  16  word width of RAM and ports
//   ADDR_W  5   RAM address width (32 words); callers truncate wider addresses
// PORTS
//   Clock    in   1       single system clock, rising edge
//   Reset    in   1       asynchronous, active-high reset
//   PReq     in   1       P request; hold with PW/PAddr/PDout stable until PAck
//   PW       in   1       P: 1=write, 0=read
//   PAddr    in   ADDR_W  P address
//   PDout    in   DATA_W  P write data
//   PAck     out  1       P one-cycle completion pulse
//   PMemOut  out  DATA_W  P read data, valid while PAck=1 after a read
//   LReq/LW/LAddr/LDout/LAck/LMemOut  same as the P group, for port L
//   RamAddr  out  ADDR_W  to ramlpm address
//   RamData  out  DATA_W  to ramlpm write data
//   RamW     out  1       to ramlpm write enable
//   RamQ     in   DATA_W  from ramlpm read data
//   Owner    out  1       port of the transaction in flight (0=P, 1=L); debug only
// BEHAVIOUR
//   Reset values
//     state=IDLE, PAck=LAck=0, PMemOut=LMemOut=0, RamW=0, RamAddr=0,
//     RamData=0, Owner=0, rr pointer=0 (P preferred).
//   FSM states: IDLE, ACCESS, RESP.
//   IDLE
//     - Samples requests; the requester acked in this cycle is masked.
//     - One eligible req: that port wins.
//     - Both eligible: winner = port not served last (pointer).
//     - On a win: latch W/Addr/Dout/id into internal regs, go to ACCESS.
//   ACCESS
//     - RamAddr/RamData driven from latched regs.
//     - RamW = latched W, for exactly this one cycle.
//     - Always go to RESP.
//   RESP
//     - RamQ holds the read word.
//     - At the end of this cycle: register RamQ into xMemOut (reads only; writes
//       leave xMemOut unchanged), set xAck=1, flip pointer to the other port.
//     - Go to IDLE.
//   Latency
//     - req sampled at edge 0 -> RamW/addr driven in cycle 1 -> Ack high in cycle 3.
//     - Every transaction occupies 3 cycles; the next may start in the ack cycle.
//   Ack and masking
//     - xAck is a registered single-cycle pulse; it is never held.
//     - In the ack cycle, the acked port's req is ignored. A held stale req does
//       not cause a replay; a new request from that port is taken from the next IDLE.
//   Ordering
//     - Both ports requesting continuously alternate strictly: P, L, P, L ...
//     - A lone requester is served back-to-back every 3 cycles.
//   Stability
//     - Request fields change after acceptance -> no effect (already latched).
//   Mid-operation reset
//     - Async return to IDLE; RamW drops immediately.
//     - In-flight access is discarded, no Ack issued; pointer returns to P.
//   Widths
//     - No arithmetic; addresses pass through unmodified, no wrap logic.
//     - Address 2^ADDR_W-1 is legal.
// STRUCTURE
//   - Shared header ram_arbiter_defs.vh: state encodings (IDLE=2'd0, ACCESS=2'd1,
//     RESP=2'd2) and port ids (PORT_P=1'b0, PORT_L=1'b1).
//   - Unused encoding 2'd3 -> IDLE.
//   - One sub-module: rr_arb2 (combinational 2-way round-robin pick from
//     masked reqs + pointer).
//   - FSM, latch regs and output regs stay in ram_arbiter.
// TESTING
//   1. Reset held 3 cycles -> PAck=LAck=0, RamW=0, Owner=0; release with no
//      reqs -> outputs stay idle.
//   2. RAM[5]=16'h1234; PReq=1,PW=0,PAddr=5 -> RamAddr=5 cycle 1; PAck=1 and
//      PMemOut=16'h1234 in cycle 3 only.
//   3. LReq write LAddr=31,LDout=16'hBEEF -> RamW=1 for one cycle with
//      RamAddr=31; LAck cycle 3; then P read 31 -> 16'hBEEF.
//   4. PReq and LReq both high from reset, held, all reads -> ack order P,L,P,L,
//      one Ack every 3 cycles, never both Acks in the same cycle.
//   5. Reset asserted during ACCESS of a P write -> RamW falls same cycle, no
//      PAck; after release, FSM in IDLE and P is served first.
//   6. PReq held high through PAck with LReq low -> exactly one transaction per
//      held request window before deassert (no replay in ack cycle).

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared FSM state encodings and port ids for the data-RAM arbiter.
// Pure definitions; no logic, no latency, no flow control.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_P = 1'b0;
    localparam logic PORT_L = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin pick from already-masked requests and a preference pointer.
// Purely combinational, zero latency; never stalls, callers hold req until served.
module rr_arb2
    import ram_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       grant_vld,
    output logic       grant_id
);

    always_comb begin
        grant_vld = |req;
        grant_id  = PORT_P;
        case (req)
            2'b01:   grant_id = PORT_P;
            2'b10:   grant_id = PORT_L;
            2'b11:   grant_id = ptr;
            default: grant_id = PORT_P;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM (registered address, 1-cycle read) between ports P and L.
// Latency: request sampled at edge 0, RAM driven cycle 1, one-cycle Ack in cycle 3.
// Backpressure: requesters hold Req and fields stable until their Ack pulse.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              PReq,
    input  logic              PW,
    input  logic [ADDR_W-1:0] PAddr,
    input  logic [DATA_W-1:0] PDout,
    output logic              PAck,
    output logic [DATA_W-1:0] PMemOut,
    input  logic              LReq,
    input  logic              LW,
    input  logic [ADDR_W-1:0] LAddr,
    input  logic [DATA_W-1:0] LDout,
    output logic              LAck,
    output logic [DATA_W-1:0] LMemOut,
    output logic [ADDR_W-1:0] RamAddr,
    output logic [DATA_W-1:0] RamData,
    output logic              RamW,
    input  logic [DATA_W-1:0] RamQ,
    output logic              Owner
);

    state_t            state, state_nxt;
    logic              lat_w;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_dout;
    logic              lat_id;
    logic              ptr;
    logic [1:0]        req_masked;
    logic              grant_vld;
    logic              grant_id;

    // A port being acked this cycle is still holding its old request; ignore it.
    assign req_masked = {LReq & ~LAck, PReq & ~PAck};

    rr_arb2 u_rr_arb2 (
        .req       (req_masked),
        .ptr       (ptr),
        .grant_vld (grant_vld),
        .grant_id  (grant_id)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            lat_w    <= 1'b0;
            lat_addr <= '0;
            lat_dout <= '0;
            lat_id   <= PORT_P;
            ptr      <= PORT_P;
            PAck     <= 1'b0;
            LAck     <= 1'b0;
            PMemOut  <= '0;
            LMemOut  <= '0;
        end else begin
            state <= state_nxt;
            PAck  <= 1'b0;
            LAck  <= 1'b0;

            if (state == IDLE && grant_vld) begin
                lat_id   <= grant_id;
                lat_w    <= (grant_id == PORT_L) ? LW    : PW;
                lat_addr <= (grant_id == PORT_L) ? LAddr : PAddr;
                lat_dout <= (grant_id == PORT_L) ? LDout : PDout;
            end

            // RamQ is valid during RESP because the RAM registered the address at the end of ACCESS.
            if (state == RESP) begin
                ptr <= ~lat_id;
                if (lat_id == PORT_L) begin
                    LAck <= 1'b1;
                    if (!lat_w) LMemOut <= RamQ;
                end else begin
                    PAck <= 1'b1;
                    if (!lat_w) PMemOut <= RamQ;
                end
            end
        end
    end

    assign RamAddr = lat_addr;
    assign RamData = lat_dout;
    assign RamW    = (state == ACCESS) && lat_w;
    assign Owner   = lat_id;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural registered-address RAM model.
module tb_ram_arbiter;

    localparam int DW = 16;
    localparam int AW = 5;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          PReq = 1'b0, PW = 1'b0;
    logic [AW-1:0] PAddr = '0;
    logic [DW-1:0] PDout = '0;
    logic          PAck;
    logic [DW-1:0] PMemOut;
    logic          LReq = 1'b0, LW = 1'b0;
    logic [AW-1:0] LAddr = '0;
    logic [DW-1:0] LDout = '0;
    logic          LAck;
    logic [DW-1:0] LMemOut;
    logic [AW-1:0] RamAddr;
    logic [DW-1:0] RamData;
    logic          RamW;
    logic [DW-1:0] RamQ;
    logic          Owner;

    int n_chk  = 0;
    int n_pass = 0;

    logic [DW-1:0] mem [0:31];
    logic [AW-1:0] addr_q = '0;
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_dat = '0;

    ram_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .PReq    (PReq),
        .PW      (PW),
        .PAddr   (PAddr),
        .PDout   (PDout),
        .PAck    (PAck),
        .PMemOut (PMemOut),
        .LReq    (LReq),
        .LW      (LW),
        .LAddr   (LAddr),
        .LDout   (LDout),
        .LAck    (LAck),
        .LMemOut (LMemOut),
        .RamAddr (RamAddr),
        .RamData (RamData),
        .RamW    (RamW),
        .RamQ    (RamQ),
        .Owner   (Owner)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (pl_en) mem[pl_addr] <= pl_dat;
        else if (RamW) mem[RamAddr] <= RamData;
        addr_q <= RamAddr;
    end
    assign RamQ = mem[addr_q];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_dat = d;
        step();
        pl_en = 1'b0;
    endtask

    initial begin
        int acks;
        logic [1:0] exp_ack;

        // 1: reset state, then idle after release
        poke(5'd5,  16'h1234);
        poke(5'd31, 16'h0000);
        poke(5'd1,  16'h0A0A);
        poke(5'd2,  16'h0B0B);
        poke(5'd7,  16'h0000);
        chk("rst_pack", PAck, 0);
        chk("rst_lack", LAck, 0);
        chk("rst_ramw", RamW, 0);
        chk("rst_owner", Owner, 0);
        chk("rst_pmemout", PMemOut, 0);
        chk("rst_ramaddr", RamAddr, 0);
        Reset = 1'b0;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (PAck || LAck || RamW) acks++;
        end
        chk("idle_after_rst", acks, 0);

        // 2: P read of address 5
        PReq = 1'b1; PW = 1'b0; PAddr = 5'd5;
        step();
        chk("t2_c1_ramaddr", RamAddr, 5);
        chk("t2_c1_ramw", RamW, 0);
        chk("t2_c1_pack", PAck, 0);
        step();
        chk("t2_c2_pack", PAck, 0);
        step();
        chk("t2_c3_pack", PAck, 1);
        chk("t2_c3_pmemout", PMemOut, 16'h1234);
        chk("t2_c3_lack", LAck, 0);
        PReq = 1'b0;
        step();
        chk("t2_c4_pack", PAck, 0);

        // 3: L write to the top address, then P reads it back
        LReq = 1'b1; LW = 1'b1; LAddr = 5'd31; LDout = 16'hBEEF;
        step();
        chk("t3_c1_ramw", RamW, 1);
        chk("t3_c1_ramaddr", RamAddr, 31);
        chk("t3_c1_ramdata", RamData, 16'hBEEF);
        chk("t3_c1_owner", Owner, 1);
        step();
        chk("t3_c2_ramw", RamW, 0);
        chk("t3_c2_lack", LAck, 0);
        step();
        chk("t3_c3_lack", LAck, 1);
        chk("t3_c3_lmemout", LMemOut, 0);
        chk("t3_mem31", mem[31], 16'hBEEF);
        LReq = 1'b0;
        PReq = 1'b1; PW = 1'b0; PAddr = 5'd31;
        step();
        PAddr = 5'd5;
        step();
        step();
        chk("t3_rd_pack", PAck, 1);
        chk("t3_rd_pmemout", PMemOut, 16'hBEEF);
        PReq = 1'b0;
        step();

        // 4: both ports requesting continuously from reset
        Reset = 1'b1;
        PReq = 1'b1; PW = 1'b0; PAddr = 5'd1;
        LReq = 1'b1; LW = 1'b0; LAddr = 5'd2;
        step();
        step();
        Reset = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            step();
            if (i % 3 == 0) exp_ack = (((i / 3) % 2) == 1) ? 2'b01 : 2'b10;
            else            exp_ack = 2'b00;
            chk($sformatf("t4_ack_c%0d", i), {LAck, PAck}, exp_ack);
            if (exp_ack == 2'b01) chk($sformatf("t4_pdata_c%0d", i), PMemOut, 16'h0A0A);
            if (exp_ack == 2'b10) chk($sformatf("t4_ldata_c%0d", i), LMemOut, 16'h0B0B);
        end
        PReq = 1'b0; LReq = 1'b0;
        step();
        step();

        // lone P read leaves the pointer favouring L
        PReq = 1'b1; PAddr = 5'd1;
        step(); step(); step();
        chk("t5_pre_pack", PAck, 1);
        PReq = 1'b0;
        step();

        // 5: reset lands during the ACCESS cycle of a P write
        PReq = 1'b1; PW = 1'b1; PAddr = 5'd7; PDout = 16'h5555;
        step();
        chk("t5_access_ramw", RamW, 1);
        #2;
        Reset = 1'b1;
        #1;
        chk("t5_rst_ramw", RamW, 0);
        chk("t5_rst_owner", Owner, 0);
        PW = 1'b0; PAddr = 5'd1;
        LReq = 1'b1; LW = 1'b0; LAddr = 5'd2;
        step();
        chk("t5_rst_pack", PAck, 0);
        chk("t5_mem7", mem[7], 0);
        Reset = 1'b0;
        step();
        chk("t5_first_owner", Owner, 0);
        chk("t5_first_ramaddr", RamAddr, 1);
        step();
        step();
        chk("t5_first_ack", {LAck, PAck}, 2'b01);
        chk("t5_first_data", PMemOut, 16'h0A0A);
        PReq = 1'b0;
        step(); step(); step();
        chk("t5_second_ack", {LAck, PAck}, 2'b10);
        chk("t5_second_data", LMemOut, 16'h0B0B);
        LReq = 1'b0;
        step();

        // 6: P request held through its ack cycle must not replay
        PReq = 1'b1; PW = 1'b0; PAddr = 5'd5;
        step(); step(); step();
        chk("t6_pack", PAck, 1);
        chk("t6_pmemout", PMemOut, 16'h1234);
        step();
        PReq = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            if (PAck || LAck) acks++;
            step();
        end
        chk("t6_no_replay", acks, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
